// File: rtl/mfp_ahb_bus_n_pkg.sv
// Shared AHB-lite codes, default slave address map and FSM state type for mfp_ahb_bus_n.
package mfp_ahb_bus_n_pkg;

   localparam logic [1:0] H_IDLE   = 2'b00;
   localparam logic [1:0] H_BUSY   = 2'b01;
   localparam logic [1:0] H_NONSEQ = 2'b10;
   localparam logic [1:0] H_SEQ    = 2'b11;

   localparam logic H_OKAY  = 1'b0;
   localparam logic H_ERROR = 1'b1;

   // Slave 0 boot RAM, 1 program RAM, 2 GPIO, 3 SSEG; slave i at bits [32i+:32].
   localparam logic [127:0] SLV_BASE_DEF = {32'h1f70_0000, 32'h1f80_0000,
                                            32'h0000_0000, 32'h1fc0_0000};
   localparam logic [127:0] SLV_MASK_DEF = {32'h1ff0_0000, 32'h1ff0_0000,
                                            32'h1fc0_0000, 32'h1fc0_0000};

   typedef enum logic [1:0] {StIdle, StSlv, StErr1, StErr2} bus_state_e;

   // Timeout counter width, clamped to 8..16 bits.
   function automatic int unsigned to_cnt_width(input int unsigned to_cyc);
      int unsigned w;
      w = $clog2(to_cyc + 1);
      if (w < 8) w = 8;
      if (w > 16) w = 16;
      return w;
   endfunction

endpackage

// File: rtl/mfp_ahb_dec_n.sv
// Priority mask/base address decoder: one-hot select of the lowest matching slave plus miss flag.
module mfp_ahb_dec_n
   import mfp_ahb_bus_n_pkg::*;
#(
   parameter int unsigned           N_SLV    = 4,
   parameter logic [N_SLV*32-1:0]   SLV_BASE = SLV_BASE_DEF,
   parameter logic [N_SLV*32-1:0]   SLV_MASK = SLV_MASK_DEF
) (
   input  logic [28:0]      haddr_i,
   output logic [N_SLV-1:0] hsel_o,
   output logic             miss_o
);

   logic found;

   always_comb begin
      hsel_o = '0;
      found  = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (!found &&
             ((haddr_i & SLV_MASK[32*i +: 29]) == SLV_BASE[32*i +: 29])) begin
            hsel_o[i] = 1'b1;
            found     = 1'b1;
         end
      end
      miss_o = ~found;
   end

endmodule

// File: rtl/mfp_ahb_bus_n.sv
// Single-master AHB-lite interconnect with N slaves, wait-state aware data-phase mux and
// default ERROR slave. Optional slave-hang timeout enabled by MFP_AHB_TIMEOUT_EN.
module mfp_ahb_bus_n
   import mfp_ahb_bus_n_pkg::*;
#(
   parameter int unsigned              N_SLV    = 4,
   parameter int unsigned              DATA_W   = 32,
   parameter logic [N_SLV*32-1:0]      SLV_BASE = SLV_BASE_DEF,
   parameter logic [N_SLV*32-1:0]      SLV_MASK = SLV_MASK_DEF,
   parameter int unsigned              TO_CYC   = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [31:0]               HADDR,
   input  logic [1:0]                HTRANS,
   input  logic                      HWRITE,
   output logic [DATA_W-1:0]         HRDATA,
   output logic                      HREADY,
   output logic                      HRESP,
   output logic [N_SLV-1:0]          HSEL_S,
   input  logic [N_SLV*DATA_W-1:0]   HRDATA_S,
   input  logic [N_SLV-1:0]          HREADYOUT_S,
   input  logic [N_SLV-1:0]          HRESP_S,
   output logic                      TIMEOUT
);

   localparam logic [N_SLV:0] DSEL_DEF = {1'b1, {N_SLV{1'b0}}};

   logic [N_SLV-1:0] hsel;
   logic             miss;
   logic             active;
   logic             slv_rdy;
   logic             slv_resp;
   logic [DATA_W-1:0] slv_rdata;
   logic             to_hit;
   bus_state_e       state_q;
   bus_state_e       dec_state;
   logic [N_SLV:0]   dsel_q;
   logic [N_SLV:0]   dec_dsel;
   logic             unused_ok;

   // Write direction and the low HTRANS bit do not affect routing.
   assign unused_ok = ^{HWRITE, HTRANS[0], HADDR[31:29]};
   assign active    = HTRANS[1];

   mfp_ahb_dec_n #(
      .N_SLV    (N_SLV),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .haddr_i (HADDR[28:0]),
      .hsel_o  (hsel),
      .miss_o  (miss)
   );

   assign HSEL_S = hsel;

   always_comb begin
      if (active && !miss) begin
         dec_state = StSlv;
         dec_dsel  = {1'b0, hsel};
      end else if (active) begin
         dec_state = StErr1;
         dec_dsel  = DSEL_DEF;
      end else begin
         dec_state = StIdle;
         dec_dsel  = '0;
      end
   end

   always_comb begin
      slv_rdy   = 1'b0;
      slv_resp  = H_OKAY;
      slv_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (dsel_q[i]) begin
            slv_rdy   = HREADYOUT_S[i];
            slv_resp  = HRESP_S[i];
            slv_rdata = HRDATA_S[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      HREADY = 1'b1;
      HRESP  = H_OKAY;
      HRDATA = '0;
      case (state_q)
         StSlv: begin
            HREADY = slv_rdy;
            HRESP  = slv_resp;
            HRDATA = slv_rdata;
         end
         StErr1: begin
            HREADY = 1'b0;
            HRESP  = H_ERROR;
         end
         StErr2: HRESP = H_ERROR;
         default: ;
      endcase
   end

`ifdef MFP_AHB_TIMEOUT_EN
   localparam int unsigned          CNT_W   = to_cnt_width(TO_CYC);
   localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(TO_CYC - 1);

   logic [CNT_W-1:0] to_cnt_q;
   logic             timeout_q;

   assign to_hit  = (state_q == StSlv) && !slv_rdy && (to_cnt_q == TO_LAST);
   assign TIMEOUT = timeout_q;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else if (to_hit) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b1;
      end else if ((state_q == StSlv) && !slv_rdy) begin
         to_cnt_q  <= to_cnt_q + 1'b1;
      end else begin
         to_cnt_q  <= '0;
      end
   end
`else
   localparam int unsigned unused_to_cyc = TO_CYC;

   assign to_hit  = 1'b0;
   assign TIMEOUT = 1'b0;
`endif

   // A timeout switches dsel to the default slave so the hung slave's late ready is ignored.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= StIdle;
         dsel_q  <= '0;
      end else if (state_q == StErr1) begin
         state_q <= StErr2;
      end else if (to_hit) begin
         state_q <= StErr1;
         dsel_q  <= DSEL_DEF;
      end else if (HREADY) begin
         state_q <= dec_state;
         dsel_q  <= dec_dsel;
      end
   end

endmodule

// File: tb/tb_mfp_ahb_bus_n.sv
// Directed self-checking bench for mfp_ahb_bus_n with the default 4-slave map.
module tb_mfp_ahb_bus_n;
   import mfp_ahb_bus_n_pkg::*;

   localparam int unsigned N_SLV  = 4;
   localparam int unsigned DATA_W = 32;

   logic                    HCLK = 1'b0;
   logic                    HRESET;
   logic [31:0]             HADDR;
   logic [1:0]              HTRANS;
   logic                    HWRITE;
   logic [DATA_W-1:0]       HRDATA;
   logic                    HREADY;
   logic                    HRESP;
   logic [N_SLV-1:0]        HSEL_S;
   logic [N_SLV*DATA_W-1:0] HRDATA_S;
   logic [N_SLV-1:0]        HREADYOUT_S;
   logic [N_SLV-1:0]        HRESP_S;
   logic                    TIMEOUT;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   mfp_ahb_bus_n #(
      .N_SLV  (N_SLV),
      .DATA_W (DATA_W),
      .TO_CYC (8)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HSEL_S      (HSEL_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .TIMEOUT     (TIMEOUT)
   );

   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic [31:0] a);
      HTRANS = t;
      HADDR  = a;
      #1;
   endtask

   initial begin
      HRESET      = 1'b1;
      HTRANS      = H_IDLE;
      HADDR       = 32'h0;
      HWRITE      = 1'b0;
      HREADYOUT_S = '1;
      HRESP_S     = '0;
      HRDATA_S    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      tick();
      tick();
      HRESET = 1'b0;
      #1;
      check_eq("rst_hready", HREADY, 1);
      check_eq("rst_hresp", HRESP, 0);
      check_eq("rst_hrdata", HRDATA, 0);
      check_eq("rst_timeout", TIMEOUT, 0);
      check_eq("hsel_not_gated_by_htrans", HSEL_S, 4'b0010);

      // Zero-wait read from program RAM.
      drive(H_NONSEQ, 32'h0000_0010);
      check_eq("rd_hsel", HSEL_S, 4'b0010);
      tick();
      drive(H_IDLE, 32'h0);
      check_eq("rd_hready", HREADY, 1);
      check_eq("rd_hrdata", HRDATA, 32'hDEAD_BEEF);
      check_eq("rd_hresp", HRESP, 0);
      tick();
      check_eq("rd_idle_hrdata", HRDATA, 0);

      // GPIO holds HREADYOUT low for three cycles while the next address is held.
      drive(H_NONSEQ, 32'h1f80_0000);
      check_eq("ws_hsel", HSEL_S, 4'b0100);
      tick();
      HREADYOUT_S[2] = 1'b0;
      drive(H_NONSEQ, 32'h0000_0010);
      for (int k = 0; k < 3; k++) begin
         check_eq("ws_hready_low", HREADY, 0);
         check_eq("ws_dsel_held", HRDATA, 32'h2222_2222);
         check_eq("ws_next_hsel", HSEL_S, 4'b0010);
         tick();
      end
      HREADYOUT_S[2] = 1'b1;
      #1;
      check_eq("ws_release_hready", HREADY, 1);
      check_eq("ws_release_hrdata", HRDATA, 32'h2222_2222);
      tick();
      drive(H_IDLE, 32'h0);
      check_eq("ws_next_hrdata", HRDATA, 32'hDEAD_BEEF);
      check_eq("ws_next_hready", HREADY, 1);
      tick();

      // Unmapped NONSEQ: two-cycle ERROR, master aborts with IDLE during the first cycle.
      drive(H_NONSEQ, 32'h0C00_0000);
      check_eq("miss_hsel", HSEL_S, 4'b0000);
      check_eq("miss_addr_hready", HREADY, 1);
      tick();
      drive(H_IDLE, 32'h0);
      check_eq("err1_hready", HREADY, 0);
      check_eq("err1_hresp", HRESP, 1);
      check_eq("err1_hrdata", HRDATA, 0);
      tick();
      check_eq("err2_hready", HREADY, 1);
      check_eq("err2_hresp", HRESP, 1);
      check_eq("err2_hrdata", HRDATA, 0);
      tick();
      check_eq("post_err_hready", HREADY, 1);
      check_eq("post_err_hresp", HRESP, 0);

      // IDLE and BUSY to an unmapped address never raise ERROR.
      drive(H_IDLE, 32'h0C00_0000);
      tick();
      check_eq("idle_miss_hready", HREADY, 1);
      check_eq("idle_miss_hresp", HRESP, 0);
      drive(H_BUSY, 32'h0C00_0000);
      tick();
      check_eq("busy_miss_hready", HREADY, 1);
      check_eq("busy_miss_hresp", HRESP, 0);

      // Slave ERROR response and data pass through from SSEG.
      drive(H_SEQ, 32'h1f70_0004);
      check_eq("sseg_hsel", HSEL_S, 4'b1000);
      tick();
      HRESP_S[3] = 1'b1;
      drive(H_IDLE, 32'h0);
      check_eq("slv_err_hresp", HRESP, 1);
      check_eq("slv_err_hrdata", HRDATA, 32'h3333_3333);
      check_eq("slv_err_hready", HREADY, 1);
      tick();
      HRESP_S[3] = 1'b0;

      // GPIO stalls for 20 cycles.
      drive(H_NONSEQ, 32'h1f80_0000);
      tick();
      HREADYOUT_S[2] = 1'b0;
      drive(H_IDLE, 32'h0);
`ifdef MFP_AHB_TIMEOUT_EN
      for (int k = 0; k < 8; k++) begin
         check_eq("to_wait_hready", HREADY, 0);
         check_eq("to_wait_hresp", HRESP, 0);
         check_eq("to_wait_flag", TIMEOUT, 0);
         tick();
      end
      check_eq("to_err1_hready", HREADY, 0);
      check_eq("to_err1_hresp", HRESP, 1);
      check_eq("to_err1_flag", TIMEOUT, 1);
      tick();
      check_eq("to_err2_hready", HREADY, 1);
      check_eq("to_err2_hresp", HRESP, 1);
      tick();
      check_eq("to_after_hready", HREADY, 1);
      check_eq("to_after_hresp", HRESP, 0);
      for (int k = 0; k < 10; k++) tick();
      HREADYOUT_S[2] = 1'b1;
      #1;
      check_eq("to_late_ready_hresp", HRESP, 0);
      check_eq("to_sticky", TIMEOUT, 1);
      tick();
      check_eq("to_sticky_later", TIMEOUT, 1);
`else
      for (int k = 0; k < 20; k++) begin
         check_eq("stall_hready", HREADY, 0);
         check_eq("stall_timeout", TIMEOUT, 0);
         tick();
      end
      HREADYOUT_S[2] = 1'b1;
      #1;
      check_eq("stall_release_hready", HREADY, 1);
      check_eq("stall_release_hresp", HRESP, 0);
      tick();
`endif

      // Reset asserted during a slave wait state.
      drive(H_NONSEQ, 32'h1f80_0000);
      tick();
      HREADYOUT_S[2] = 1'b0;
      drive(H_IDLE, 32'h0);
      check_eq("pre_rst_hready", HREADY, 0);
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      #1;
      check_eq("mid_rst_hready", HREADY, 1);
      check_eq("mid_rst_hresp", HRESP, 0);
      check_eq("mid_rst_hrdata", HRDATA, 0);
      check_eq("mid_rst_timeout", TIMEOUT, 0);
      HREADYOUT_S[2] = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
